// File: rtl/dpram_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_rr_arbiter_pkg
//  Brief    : Shared client identifiers and arbiter state encoding for the
//             two-client dual-port RAM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package dpram_rr_arbiter_pkg;

   localparam logic CLIENT0     = 1'b0;
   localparam logic CLIENT1     = 1'b1;
   localparam int   NUM_CLIENTS = 2;

   // Priority pointer of one port: the client that wins when both request.
   typedef enum logic {
      PRI0 = 1'b0,
      PRI1 = 1'b1
   } pri_state_t;

endpackage : dpram_rr_arbiter_pkg
`default_nettype wire

// File: rtl/dpram_rr_arbiter_dpram.sv
`default_nettype none
// ============================================================================
//  Module   : dpram
//  Brief    : Simple dual-port RAM, one write port and one registered read
//             port. Reads return the pre-write value on a same-address
//             collision. The read register clears on reset; contents do not.
//  Revision : 1.0 - initial release
// ============================================================================
module dpram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  read_clock,
   input  logic                  write_clock,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic                  we,
   output logic [DATA_WIDTH-1:0] q
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port: store the word at the edge where we is high.
   always_ff @(posedge write_clock) begin
      if (we) begin
         mem[write_addr] <= data;
      end
   end

   // Read port: registered output, cleared on reset.
   always_ff @(posedge read_clock) begin
      if (rst) begin
         q <= '0;
      end else begin
         q <= mem[read_addr];
      end
   end

endmodule : dpram
`default_nettype wire

// File: rtl/dpram_rr_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-way round-robin arbiter with its own priority pointer.
//             Grant is combinational from the requests and the pointer; the
//             pointer moves to the other client after every grant.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
   import dpram_rr_arbiter_pkg::*;
(
   input  logic                   clock,
   input  logic                   rst,
   input  logic [NUM_CLIENTS-1:0] req,
   output logic [NUM_CLIENTS-1:0] gnt,
   output logic                   gnt_idx
);

   pri_state_t state;
   pri_state_t state_next;

   // Priority pointer register; client 0 has priority out of reset.
   always_ff @(posedge clock) begin
      if (rst) begin
         state <= PRI0;
      end else begin
         state <= state_next;
      end
   end

   // Grant selection and pointer update; nothing is granted during reset.
   always_comb begin
      gnt        = '0;
      gnt_idx    = CLIENT0;
      state_next = state;
      if (!rst) begin
         case (req)
            2'b01: begin
               gnt_idx = CLIENT0;
               gnt     = 2'b01;
            end
            2'b10: begin
               gnt_idx = CLIENT1;
               gnt     = 2'b10;
            end
            2'b11: begin
               gnt_idx = (state == PRI1) ? CLIENT1 : CLIENT0;
               gnt     = (state == PRI1) ? 2'b10 : 2'b01;
            end
            default: begin
               gnt     = '0;
            end
         endcase
         if (gnt != '0) begin
            state_next = (gnt_idx == CLIENT1) ? PRI0 : PRI1;
         end
      end
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dpram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dpram_rr_arbiter
//  Brief    : Shares one dual-port RAM between two clients. Write and read
//             ports are arbitrated independently with round-robin priority;
//             read data comes back one cycle after acceptance, tagged by a
//             per-client valid strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module dpram_rr_arbiter
   import dpram_rr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  c0_wr_valid,
   output logic                  c0_wr_ready,
   input  logic [ADDR_WIDTH-1:0] c0_wr_addr,
   input  logic [DATA_WIDTH-1:0] c0_wr_data,
   input  logic                  c0_rd_valid,
   output logic                  c0_rd_ready,
   input  logic [ADDR_WIDTH-1:0] c0_rd_addr,
   output logic                  c0_rd_data_valid,
   input  logic                  c1_wr_valid,
   output logic                  c1_wr_ready,
   input  logic [ADDR_WIDTH-1:0] c1_wr_addr,
   input  logic [DATA_WIDTH-1:0] c1_wr_data,
   input  logic                  c1_rd_valid,
   output logic                  c1_rd_ready,
   input  logic [ADDR_WIDTH-1:0] c1_rd_addr,
   output logic                  c1_rd_data_valid,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [NUM_CLIENTS-1:0] wr_gnt;
   logic [NUM_CLIENTS-1:0] rd_gnt;
   logic                   wr_idx;
   logic                   rd_idx;
   logic [ADDR_WIDTH-1:0]  wr_addr;
   logic [DATA_WIDTH-1:0]  wr_data;
   logic [ADDR_WIDTH-1:0]  rd_addr;
   logic                   we;
   logic                   rd_pending;
   logic                   rd_client;

   rr_arb2 u_wr_arb (
      .clock   (clock),
      .rst     (rst),
      .req     ({c1_wr_valid, c0_wr_valid}),
      .gnt     (wr_gnt),
      .gnt_idx (wr_idx)
   );

   rr_arb2 u_rd_arb (
      .clock   (clock),
      .rst     (rst),
      .req     ({c1_rd_valid, c0_rd_valid}),
      .gnt     (rd_gnt),
      .gnt_idx (rd_idx)
   );

   assign c0_wr_ready = wr_gnt[CLIENT0];
   assign c1_wr_ready = wr_gnt[CLIENT1];
   assign c0_rd_ready = rd_gnt[CLIENT0];
   assign c1_rd_ready = rd_gnt[CLIENT1];

   assign wr_addr = (wr_idx == CLIENT1) ? c1_wr_addr : c0_wr_addr;
   assign wr_data = (wr_idx == CLIENT1) ? c1_wr_data : c0_wr_data;
   assign rd_addr = (rd_idx == CLIENT1) ? c1_rd_addr : c0_rd_addr;
   assign we      = |wr_gnt;

   // Remember which client owns the word arriving on rd_data next cycle.
   always_ff @(posedge clock) begin
      if (rst) begin
         rd_pending <= 1'b0;
         rd_client  <= CLIENT0;
      end else begin
         rd_pending <= |rd_gnt;
         rd_client  <= rd_idx;
      end
   end

   // Masking with rst drops a response whose request was accepted just
   // before reset rose; the client reissues it afterwards.
   assign c0_rd_data_valid = rd_pending && !rst && (rd_client == CLIENT0);
   assign c1_rd_data_valid = rd_pending && !rst && (rd_client == CLIENT1);

   dpram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .read_clock  (clock),
      .write_clock (clock),
      .rst         (rst),
      .data        (wr_data),
      .read_addr   (rd_addr),
      .write_addr  (wr_addr),
      .we          (we),
      .q           (rd_data)
   );

endmodule : dpram_rr_arbiter
`default_nettype wire

// File: tb/tb_dpram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dpram_rr_arbiter
//  Brief    : Directed self-checking bench for dpram_rr_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dpram_rr_arbiter;

   logic       clock = 1'b0;
   logic       rst   = 1'b1;
   logic       c0_wr_valid = 1'b0, c1_wr_valid = 1'b0;
   logic       c0_rd_valid = 1'b0, c1_rd_valid = 1'b0;
   logic [5:0] c0_wr_addr = '0, c1_wr_addr = '0, c0_rd_addr = '0, c1_rd_addr = '0;
   logic [7:0] c0_wr_data = '0, c1_wr_data = '0;
   logic       c0_wr_ready, c1_wr_ready, c0_rd_ready, c1_rd_ready;
   logic       c0_rd_data_valid, c1_rd_data_valid;
   logic [7:0] rd_data;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] exp_c0 [2];
   logic [7:0] exp_c1 [2];

   dpram_rr_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
      .clock            (clock),
      .rst              (rst),
      .c0_wr_valid      (c0_wr_valid),
      .c0_wr_ready      (c0_wr_ready),
      .c0_wr_addr       (c0_wr_addr),
      .c0_wr_data       (c0_wr_data),
      .c0_rd_valid      (c0_rd_valid),
      .c0_rd_ready      (c0_rd_ready),
      .c0_rd_addr       (c0_rd_addr),
      .c0_rd_data_valid (c0_rd_data_valid),
      .c1_wr_valid      (c1_wr_valid),
      .c1_wr_ready      (c1_wr_ready),
      .c1_wr_addr       (c1_wr_addr),
      .c1_wr_data       (c1_wr_data),
      .c1_rd_valid      (c1_rd_valid),
      .c1_rd_ready      (c1_rd_ready),
      .c1_rd_addr       (c1_rd_addr),
      .c1_rd_data_valid (c1_rd_data_valid),
      .rd_data          (rd_data)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wr0(input logic [5:0] a, input logic [7:0] d);
      c0_wr_valid = 1'b1;
      c0_wr_addr  = a;
      c0_wr_data  = d;
      tick();
      c0_wr_valid = 1'b0;
   endtask

   initial begin
      exp_c0[0] = 8'h31; exp_c0[1] = 8'h32;
      exp_c1[0] = 8'h42; exp_c1[1] = 8'h43;

      // Initial reset, then clear mem[5] so the reset-hold test starts from a known 0.
      do_reset();
      wr0(6'd5, 8'h00);

      // Test 1: reset held 3 cycles with every request active.
      rst = 1'b1;
      c0_wr_valid = 1'b1; c0_wr_addr = 6'd5; c0_wr_data = 8'h5A;
      c1_wr_valid = 1'b1; c1_wr_addr = 6'd5; c1_wr_data = 8'h5B;
      c0_rd_valid = 1'b1; c0_rd_addr = 6'd5;
      c1_rd_valid = 1'b1; c1_rd_addr = 6'd5;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_c0_wr_ready", 32'(c0_wr_ready), 0);
         check("rst_c1_wr_ready", 32'(c1_wr_ready), 0);
         check("rst_c0_rd_ready", 32'(c0_rd_ready), 0);
         check("rst_c1_rd_ready", 32'(c1_rd_ready), 0);
         check("rst_c0_rd_dv", 32'(c0_rd_data_valid), 0);
         check("rst_c1_rd_dv", 32'(c1_rd_data_valid), 0);
         check("rst_rd_data", 32'(rd_data), 0);
      end
      c0_wr_valid = 1'b0; c1_wr_valid = 1'b0; c1_rd_valid = 1'b0;
      rst = 1'b0;
      c0_rd_addr = 6'd5;
      settle();
      check("post_rst_c0_rd_ready", 32'(c0_rd_ready), 1);
      tick();
      c0_rd_valid = 1'b0;
      settle();
      check("no_write_in_rst_dv", 32'(c0_rd_data_valid), 1);
      check("no_write_in_rst_data", 32'(rd_data), 32'h00);

      // Test 2: single client write then read.
      c0_wr_valid = 1'b1; c0_wr_addr = 6'd5; c0_wr_data = 8'hA5;
      settle();
      check("single_c0_wr_ready", 32'(c0_wr_ready), 1);
      tick();
      c0_wr_valid = 1'b0;
      c0_rd_valid = 1'b1; c0_rd_addr = 6'd5;
      settle();
      check("single_c0_rd_ready", 32'(c0_rd_ready), 1);
      tick();
      c0_rd_valid = 1'b0;
      settle();
      check("single_c0_dv", 32'(c0_rd_data_valid), 1);
      check("single_c1_dv", 32'(c1_rd_data_valid), 0);
      check("single_data", 32'(rd_data), 32'hA5);
      tick();
      check("single_c0_dv_one_cycle", 32'(c0_rd_data_valid), 0);

      // Test 3: write contention, grants alternate from reset.
      do_reset();
      c0_wr_valid = 1'b1; c0_wr_addr = 6'd2; c0_wr_data = 8'h11;
      c1_wr_valid = 1'b1; c1_wr_addr = 6'd3; c1_wr_data = 8'h22;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("cont_c0_wr_ready", 32'(c0_wr_ready), (i % 2 == 0) ? 1 : 0);
         check("cont_c1_wr_ready", 32'(c1_wr_ready), (i % 2 == 0) ? 0 : 1);
         tick();
      end
      c0_wr_valid = 1'b0; c1_wr_valid = 1'b0;
      c0_rd_valid = 1'b1; c0_rd_addr = 6'd2;
      tick();
      c0_rd_valid = 1'b0;
      c1_rd_valid = 1'b1; c1_rd_addr = 6'd3;
      settle();
      check("cont_rb_c0_dv", 32'(c0_rd_data_valid), 1);
      check("cont_rb_c0_data", 32'(rd_data), 32'h11);
      tick();
      c1_rd_valid = 1'b0;
      settle();
      check("cont_rb_c1_dv", 32'(c1_rd_data_valid), 1);
      check("cont_rb_c0_dv_low", 32'(c0_rd_data_valid), 0);
      check("cont_rb_c1_data", 32'(rd_data), 32'h22);

      // Test 4: same-address read and write at the same edge.
      wr0(6'd7, 8'h10);
      c0_wr_valid = 1'b1; c0_wr_addr = 6'd7; c0_wr_data = 8'h77;
      c1_rd_valid = 1'b1; c1_rd_addr = 6'd7;
      settle();
      check("coll_c0_wr_ready", 32'(c0_wr_ready), 1);
      check("coll_c1_rd_ready", 32'(c1_rd_ready), 1);
      tick();
      c0_wr_valid = 1'b0;
      settle();
      check("coll_old_dv", 32'(c1_rd_data_valid), 1);
      check("coll_old_data", 32'(rd_data), 32'h10);
      tick();
      c1_rd_valid = 1'b0;
      settle();
      check("coll_new_dv", 32'(c1_rd_data_valid), 1);
      check("coll_new_data", 32'(rd_data), 32'h77);

      // Test 5: streaming reads from both clients.
      wr0(6'd10, 8'h31);
      wr0(6'd11, 8'h32);
      wr0(6'd20, 8'h42);
      wr0(6'd21, 8'h43);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         c0_rd_valid = 1'b1; c0_rd_addr = 6'(10 + (i + 1) / 2);
         c1_rd_valid = 1'b1; c1_rd_addr = 6'(20 + i / 2);
         settle();
         check("stream_c0_rd_ready", 32'(c0_rd_ready), (i % 2 == 0) ? 1 : 0);
         check("stream_c1_rd_ready", 32'(c1_rd_ready), (i % 2 == 0) ? 0 : 1);
         if (i > 0) begin
            if (i % 2 == 1) begin
               check("stream_c0_dv", 32'(c0_rd_data_valid), 1);
               check("stream_c1_dv_low", 32'(c1_rd_data_valid), 0);
               check("stream_c0_data", 32'(rd_data), 32'(exp_c0[(i - 1) / 2]));
            end else begin
               check("stream_c1_dv", 32'(c1_rd_data_valid), 1);
               check("stream_c0_dv_low", 32'(c0_rd_data_valid), 0);
               check("stream_c1_data", 32'(rd_data), 32'(exp_c1[(i - 2) / 2]));
            end
         end
         tick();
      end
      c0_rd_valid = 1'b0; c1_rd_valid = 1'b0;
      settle();
      check("stream_last_c1_dv", 32'(c1_rd_data_valid), 1);
      check("stream_last_c0_dv_low", 32'(c0_rd_data_valid), 0);
      check("stream_last_data", 32'(rd_data), 32'h43);

      // Test 6: reset rising right after a read is accepted.
      c0_rd_valid = 1'b1; c0_rd_addr = 6'd10;
      settle();
      check("midrst_c0_rd_ready", 32'(c0_rd_ready), 1);
      tick();
      c0_rd_valid = 1'b0;
      rst = 1'b1;
      settle();
      check("midrst_c0_dv_suppressed", 32'(c0_rd_data_valid), 0);
      check("midrst_c1_dv_low", 32'(c1_rd_data_valid), 0);
      tick();
      rst = 1'b0;
      c0_rd_valid = 1'b1; c0_rd_addr = 6'd10;
      c1_rd_valid = 1'b1; c1_rd_addr = 6'd20;
      c0_wr_valid = 1'b1; c0_wr_addr = 6'd63; c0_wr_data = 8'hEE;
      c1_wr_valid = 1'b1; c1_wr_addr = 6'd62; c1_wr_data = 8'hDD;
      settle();
      check("midrst_rd_pri_c0", 32'(c0_rd_ready), 1);
      check("midrst_rd_pri_c1", 32'(c1_rd_ready), 0);
      check("midrst_wr_pri_c0", 32'(c0_wr_ready), 1);
      tick();
      c0_rd_valid = 1'b0; c1_rd_valid = 1'b0;
      c0_wr_valid = 1'b0; c1_wr_valid = 1'b0;
      settle();
      check("midrst_reissue_dv", 32'(c0_rd_data_valid), 1);
      check("midrst_reissue_data", 32'(rd_data), 32'h31);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_dpram_rr_arbiter
`default_nettype wire
